alu_sequencer: RTL and testbench

- Multi-cycle controller that sequences one instruction at a time through the 16-bit ALU datapath.
- Accepts a 32-bit instruction word over a valid/ready handshake and reads operands from the register file through a single read port.
- Drives the ALU opcode and operands, waits an opcode-dependent latency, then writes results back through a single write port.
- Sits between the instruction fetch/decode stage and the ALU + register file; replaces direct combinational register-to-ALU wiring.

---
 rtl/alu_sequencer_pkg.sv | 43 ++++
 rtl/alu_sequencer_lat_cnt.sv | 47 ++++
 rtl/alu_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - opcodes, instruction fields, state encoding and error codes for alu_sequencer
package alu_sequencer_pkg;

    localparam logic [5:0] OP_MOVI = 6'b000000;
    localparam logic [5:0] OP_MOV  = 6'b000001;
    localparam logic [5:0] OP_ADD  = 6'b000100;
    localparam logic [5:0] OP_SUB  = 6'b000101;
    localparam logic [5:0] OP_NEG  = 6'b000110;
    localparam logic [5:0] OP_MUL  = 6'b000111;
    localparam logic [5:0] OP_DIV  = 6'b001000;
    localparam logic [5:0] OP_NOT  = 6'b001110;
    localparam logic [5:0] OP_LRSH = 6'b010000;

    localparam int OP_LSB    = 26;
    localparam int RDST2_LSB = 21;
    localparam int RDST1_LSB = 16;
    localparam int RSRC2_LSB = 11;
    localparam int RSRC1_LSB = 6;
    localparam int IMM_LSB   = 0;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_A  = 3'd1,
        ST_RD_B  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_WB_LO = 3'd4,
        ST_WB_HI = 3'd5
    } state_t;

    // MOVI, MOV and the contiguous ALU block ADD..LRSH are the only decodable ops
    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_MOVI) || (op == OP_MOV) || ((op >= OP_ADD) && (op <= OP_LRSH));
    endfunction

    function automatic logic op_unary(input logic [5:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/alu_sequencer_lat_cnt.sv
// rtl/alu_sequencer_lat_cnt.sv - EXEC latency down-counter; last marks the final EXEC cycle
module alu_seq_lat_cnt
    import alu_sequencer_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] op,
    output logic       last
);

    logic [15:0] cnt;
    logic [15:0] lat_sel;

    // A latency below one would never produce last, so clamp it
    function automatic logic [15:0] clamp_lat(input int lat);
        return (lat < 1) ? 16'd1 : 16'(lat);
    endfunction

    // Pick the latency for the opcode being loaded
    always_comb begin
        lat_sel = clamp_lat(ALU_LAT);
        if (op == OP_MUL) begin
            lat_sel = clamp_lat(MUL_LAT);
        end else if (op == OP_DIV) begin
            lat_sel = clamp_lat(DIV_LAT);
        end
    end

    // Load on entry to EXEC, then count down and park at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= lat_sel;
        end else if (cnt > 16'd1) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign last = (cnt == 16'd1);

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ALU instruction sequencer; optional ALU_SEQ_STATS_EN adds retired/stall counters
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  rf_raddr,
    input  logic [15:0] rf_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [5:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0] retired_cnt,
    output logic [15:0] stall_cnt
`endif
);

    state_t      state_q, state_d;
    logic [31:0] instr_q;
    logic [15:0] alu_a_q, alu_b_q;
    logic [31:0] result_q;
    logic [1:0]  err_code_q, err_code_d;
    logic        exec_load;
    logic        lat_last;

    logic [5:0]  op_q, op_in;
    logic [4:0]  rd2_q, rd1_q, rs2_q, rs1_q;
    logic [15:0] imm_q;

    assign op_in = instr[OP_LSB +: 6];
    assign op_q  = instr_q[OP_LSB +: 6];
    assign rd2_q = instr_q[RDST2_LSB +: 5];
    assign rd1_q = instr_q[RDST1_LSB +: 5];
    assign rs2_q = instr_q[RSRC2_LSB +: 5];
    assign rs1_q = instr_q[RSRC1_LSB +: 5];
    assign imm_q = instr_q[IMM_LSB +: 16];

    alu_seq_lat_cnt #(
        .ALU_LAT (ALU_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (exec_load),
        .op    (op_q),
        .last  (lat_last)
    );

    // Next state; err_code is rewritten on entry to each instruction's done cycle
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        exec_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    if (op_in == OP_MOVI) begin
                        state_d    = ST_WB_LO;
                        err_code_d = ERR_NONE;
                    end else if (!op_legal(op_in)) begin
                        state_d    = ST_WB_LO;
                        err_code_d = ERR_ILLEGAL;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                if (op_q == OP_MOV) begin
                    state_d    = ST_WB_LO;
                    err_code_d = ERR_NONE;
                end else if (op_unary(op_q)) begin
                    state_d   = ST_EXEC;
                    exec_load = 1'b1;
                end else begin
                    state_d = ST_RD_B;
                end
            end
            ST_RD_B: begin
                if ((op_q == OP_DIV) && (alu_a_q == 16'h0000)) begin
                    state_d    = ST_WB_LO;
                    err_code_d = ERR_DIV0;
                end else begin
                    state_d   = ST_EXEC;
                    exec_load = 1'b1;
                end
            end
            ST_EXEC: begin
                if (lat_last) begin
                    state_d = ST_WB_LO;
                    if (op_q != OP_MUL) begin
                        err_code_d = ERR_NONE;
                    end
                end
            end
            ST_WB_LO: begin
                if (op_q == OP_MUL) begin
                    state_d    = ST_WB_HI;
                    err_code_d = ERR_NONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB_HI: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Register-file port and completion outputs decoded from the current state
    always_comb begin
        rf_raddr = '0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        done     = 1'b0;
        case (state_q)
            ST_RD_A: rf_raddr = rs1_q;
            ST_RD_B: rf_raddr = rs2_q;
            ST_WB_LO: begin
                rf_we    = (err_code_q == ERR_NONE);
                rf_waddr = rd1_q;
                if (op_q == OP_MOVI) begin
                    rf_wdata = imm_q;
                end else if (op_q == OP_MOV) begin
                    rf_wdata = alu_a_q;
                end else begin
                    rf_wdata = result_q[15:0];
                end
                done = (op_q != OP_MUL);
            end
            ST_WB_HI: begin
                rf_we    = 1'b1;
                rf_waddr = rd2_q;
                rf_wdata = result_q[31:16];
                done     = 1'b1;
            end
            default: ;
        endcase
    end

    // State, latched instruction, captured operands and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            instr_q    <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            result_q   <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            if ((state_q == ST_IDLE) && instr_valid) begin
                instr_q <= instr;
            end
            if (state_q == ST_RD_A) begin
                alu_a_q <= rf_rdata;
                if (op_unary(op_q)) begin
                    alu_b_q <= '0;
                end
            end
            if (state_q == ST_RD_B) begin
                alu_b_q <= rf_rdata;
            end
            if ((state_q == ST_EXEC) && lat_last) begin
                result_q <= alu_result;
            end
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign alu_op      = op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign err         = done && (err_code_q != ERR_NONE);
    assign err_code    = err_code_q;

`ifdef ALU_SEQ_STATS_EN
    logic exec_prev_q;

    // Retired/stall counters; exec_prev_q marks EXEC cycles after the first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
            exec_prev_q <= 1'b0;
        end else begin
            exec_prev_q <= (state_q == ST_EXEC);
            if (done && !err) begin
                retired_cnt <= retired_cnt + 16'd1;
            end
            if ((state_q == ST_EXEC) && exec_prev_q) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - randomized self-checking bench for alu_sequencer against an instruction-level model
module tb_alu_sequencer;

    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [4:0]  rf_raddr;
    logic [15:0] rf_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [5:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] retired_cnt;
    logic [15:0] stall_cnt;
`endif

    logic [15:0] rf [32];
    logic [4:0]  wq_a [$];
    logic [15:0] wq_d [$];
    int n_checks = 0;
    int n_errors = 0;
    int exp_retired = 0;
    int exp_stall = 0;

    always #5 clk = ~clk;

    // Stand-in ALU: arbitrary but fixed function of opcode and operands
    function automatic logic [31:0] alu_model(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            6'd4:    alu_model = {15'h0, {1'b0, a} + {1'b0, b}};
            6'd6:    alu_model = {16'h0, 16'h0 - a};
            6'd7:    alu_model = {16'h0, a} * {16'h0, b};
            6'd8:    alu_model = (a == 16'h0) ? 32'hDEAD_BEEF : {16'h0, b / a};
            6'd14:   alu_model = {16'h0, ~a};
            default: alu_model = {a ^ b, a - b + {10'h0, op}};
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd2, input logic [4:0] rd1,
                                       input logic [4:0] rs2, input logic [4:0] rs1, input logic [5:0] lo);
        return {op, rd2, rd1, rs2, rs1, lo};
    endfunction

    assign rf_rdata   = rf[rf_raddr];
    assign alu_result = alu_model(alu_op, alu_a, alu_b);

    alu_sequencer #(
        .ALU_LAT (ALU_LAT),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rf_raddr    (rf_raddr),
        .rf_rdata    (rf_rdata),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code)
`ifdef ALU_SEQ_STATS_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // Record every register-file write in order
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            wq_a.push_back(rf_waddr);
            wq_d.push_back(rf_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_instr(input logic [31:0] iw);
        logic [5:0]  op;
        logic [4:0]  rd2, rd1, rs2, rs1;
        logic [15:0] a, b, imm;
        logic [31:0] r;
        logic [1:0]  code;
        logic [4:0]  ea [2];
        logic [15:0] ed [2];
        int lat, exec_c, exec_len, n_exp, c, base, nw;
        bit seen, legal, unary;

        op  = iw[31:26]; rd2 = iw[25:21]; rd1 = iw[20:16];
        rs2 = iw[15:11]; rs1 = iw[10:6];  imm = iw[15:0];
        a = rf[rs1]; b = rf[rs2];
        code = 2'b00; n_exp = 0; exec_c = 0; exec_len = 0;
        ea[0] = '0; ea[1] = '0; ed[0] = '0; ed[1] = '0;
        legal = (op <= 6'd1) || (op >= 6'd4 && op <= 6'd16);
        unary = (op == 6'd6) || (op == 6'd14);
        if (!legal) begin
            lat = 1; code = 2'b01;
        end else if (op == 6'd0) begin
            lat = 1; ea[0] = rd1; ed[0] = imm; n_exp = 1;
        end else if (op == 6'd1) begin
            lat = 2; ea[0] = rd1; ed[0] = a; n_exp = 1;
        end else if (unary) begin
            b = 16'h0; exec_c = 2; exec_len = ALU_LAT; lat = 2 + ALU_LAT;
        end else if (op == 6'd8 && a == 16'h0) begin
            lat = 3; code = 2'b10;
        end else if (op == 6'd7) begin
            exec_c = 3; exec_len = MUL_LAT; lat = 4 + MUL_LAT;
        end else if (op == 6'd8) begin
            exec_c = 3; exec_len = DIV_LAT; lat = 3 + DIV_LAT;
        end else begin
            exec_c = 3; exec_len = ALU_LAT; lat = 3 + ALU_LAT;
        end
        if (exec_c != 0) begin
            r = alu_model(op, a, b);
            ea[0] = rd1; ed[0] = r[15:0]; n_exp = 1;
            if (op == 6'd7) begin
                ea[1] = rd2; ed[1] = r[31:16]; n_exp = 2;
            end
            exp_stall += exec_len - 1;
        end
        if (code == 2'b00) exp_retired++;

        base = wq_a.size();
        check("ready_before", {31'h0, instr_ready}, 32'd1);
        instr = iw;
        instr_valid = 1'b1;
        @(posedge clk);
        seen = 0; c = 0;
        while (!seen && c < 100) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                instr_valid = 1'b0;
                instr = $urandom;
            end
            if (exec_c != 0 && c == exec_c) begin
                check("alu_op", {26'h0, alu_op}, {26'h0, op});
                check("alu_a", {16'h0, alu_a}, {16'h0, a});
                check("alu_b", {16'h0, alu_b}, {16'h0, b});
            end
            if (done === 1'b1) begin
                seen = 1;
                check("latency", c, lat);
                check("err", {31'h0, err}, {31'h0, code != 2'b00});
                check("err_code", {30'h0, err_code}, {30'h0, code});
                check("ready_in_done", {31'h0, instr_ready}, 32'd0);
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        check("err_code_hold", {30'h0, err_code}, {30'h0, code});
        check("busy_after", {31'h0, busy}, 32'd0);
        nw = wq_a.size() - base;
        check("n_writes", nw, n_exp);
        for (int i = 0; i < n_exp && i < nw; i++) begin
            check("waddr", {27'h0, wq_a[base + i]}, {27'h0, ea[i]});
            check("wdata", {16'h0, wq_d[base + i]}, {16'h0, ed[i]});
        end
        for (int i = 0; i < nw; i++) rf[wq_a[base + i]] = wq_d[base + i];
    endtask

    initial begin
        int base, nrdy, ndone, nerr, pick;
        logic [5:0] rop;

        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        for (int i = 0; i < 32; i++) rf[i] = 16'h0;
        repeat (2) @(negedge clk);

        check("rst_ready", {31'h0, instr_ready}, 32'd1);
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_err", {31'h0, err}, 32'd0);
        check("rst_err_code", {30'h0, err_code}, 32'd0);
        check("rst_we", {31'h0, rf_we}, 32'd0);
        check("rst_regs", {rf_waddr, rf_wdata, rf_raddr, alu_op}, 32'd0);
        check("rst_ops", {alu_a, alu_b}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a DIV's EXEC phase
        rf[1] = 16'd3; rf[2] = 16'd100;
        base = wq_a.size();
        instr = mk(6'd8, 5'd0, 5'd9, 5'd2, 5'd1, 6'd0);
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_busy", {31'h0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, instr_ready}, 32'd1);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_we", {31'h0, rf_we}, 32'd0);
        check("abort_ops", {alu_a, alu_b}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_write", wq_a.size() - base, 32'd0);
        exp_retired = 0;
        exp_stall = 0;

        // Directed cases
        run_instr(mk(6'd0, 5'd0, 5'd3, 5'd2, 5'd8, 6'h34));
        check("movi_r3", {16'h0, rf[3]}, 32'h1234);
        rf[1] = 16'd5; rf[2] = 16'd7;
        run_instr(mk(6'd4, 5'd0, 5'd4, 5'd2, 5'd1, 6'd0));
        check("add_r4", {16'h0, rf[4]}, 32'd12);
        rf[1] = 16'h0100; rf[2] = 16'h0300;
        run_instr(mk(6'd7, 5'd6, 5'd5, 5'd2, 5'd1, 6'd0));
        check("mul_r5", {16'h0, rf[5]}, 32'h0000);
        check("mul_r6", {16'h0, rf[6]}, 32'h0003);
        run_instr(mk(6'd7, 5'd9, 5'd9, 5'd2, 5'd1, 6'd0));
        check("mul_same_dst", {16'h0, rf[9]}, 32'h0003);
        rf[1] = 16'h0;
        run_instr(mk(6'd8, 5'd0, 5'd7, 5'd2, 5'd1, 6'd0));
        rf[1] = 16'd5;
        run_instr(mk(6'd4, 5'd0, 5'd4, 5'd2, 5'd1, 6'd0));
        run_instr(mk(6'd4, 5'd0, 5'd1, 5'd1, 5'd1, 6'd0));
        check("src_eq_dst", {16'h0, rf[1]}, 32'd10);
        run_instr(32'hFFFF_FFFF);

        // Illegal opcode held valid back-to-back: one accept per two cycles
        base = wq_a.size();
        nrdy = 0; ndone = 0; nerr = 0;
        instr = 32'hFC00_0000;
        instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (instr_ready === 1'b1) nrdy++;
            if (done === 1'b1) ndone++;
            if (err === 1'b1) nerr++;
            if (i < 9) @(negedge clk);
        end
        instr_valid = 1'b0;
        @(negedge clk);
        check("b2b_accepts", nrdy, 32'd5);
        check("b2b_dones", ndone, 32'd5);
        check("b2b_errs", nerr, 32'd5);
        check("b2b_no_write", wq_a.size() - base, 32'd0);
        check("b2b_err_code", {30'h0, err_code}, 32'd1);

        // Randomized instruction mix
        for (int i = 0; i < 32; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0: rop = 6'd0;
                1: rop = 6'd1;
                2: rop = 6'd4;
                3: rop = 6'd5;
                4: rop = 6'd6;
                5: rop = 6'd7;
                6: rop = 6'd8;
                7: rop = 6'd14;
                8: rop = 6'($urandom_range(9, 16));
                default: rop = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(2, 3)) : 6'($urandom_range(17, 63));
            endcase
            run_instr({rop, 26'($urandom)});
        end

`ifdef ALU_SEQ_STATS_EN
        check("retired_cnt", {16'h0, retired_cnt}, 32'(exp_retired & 16'hFFFF));
        check("stall_cnt", {16'h0, stall_cnt}, 32'(exp_stall & 16'hFFFF));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
